multicycle_sequencer: RTL and testbench
=======================================

Name: multicycle_sequencer

Overview:
- Multi-cycle FSM that steps the RV64 core through FETCH, DECODE, EXEC, MEM and WB, one instruction at a time.
- Consumes the decoder's mem_read, mem_write, reg_write and illegal outputs, latched for the current instruction.
- Drives the instruction-register, PC and register-file write enables, plus request/ack handshakes to instruction and data memory.
- Counts retired instructions and halts on an illegal instruction or a memory timeout.

Parameters:
- MEM_TIMEOUT, 255: maximum consecutive request cycles without an ack before a timeout error; 0 disables the timeout.
- CNT_WIDTH, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- imem_req  out  1  instruction fetch request
- imem_ack  in  1  fetch data valid / accepted
- dmem_req  out  1  data memory request
- dmem_we  out  1  data request is a write (valid only with dmem_req)
- dmem_ack  in  1  data access complete
- dec_mem_read  in  1  decoded load
- dec_mem_write  in  1  decoded store
- dec_reg_write  in  1  decoded register writeback
- dec_illegal  in  1  decoder flagged unknown or unimplemented encoding
- ir_we  out  1  latch instruction register
- pc_we  out  1  update PC
- reg_we  out  1  register-file write enable
- retire  out  1  one-cycle pulse per completed instruction
- retired_cnt  out  CNT_WIDTH  retired-instruction count
- state  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5
- halted  out  1  in HALT
- illegal_err  out  1  sticky: halted on an illegal instruction
- timeout_err  out  1  sticky: halted on a memory timeout

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- Reset: state=FETCH, wait counter=0, retired_cnt=0, illegal_err=0, timeout_err=0.
  - All strobes (imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_we, retire) are forced 0 while rst=1.
  - imem_req rises in the first cycle after rst falls.
- Strobes are combinational from state and the ack inputs; state, counters and error flags are registered.
- FETCH:
  - imem_req=1 until imem_ack.
  - In the ack cycle: ir_we=1, then go to DECODE.
- DECODE (1 cycle):
  - If dec_illegal, or dec_mem_read and dec_mem_write are both set: go to HALT and set illegal_err.
  - Otherwise go to EXEC.
- EXEC (1 cycle):
  - If mem_read or mem_write: go to MEM.
  - Else if reg_write: go to WB.
  - Else: pc_we=1 and retire=1, then go to FETCH (branches, stores to nothing, NOP-like).
- MEM:
  - dmem_req=1 and dmem_we=dec_mem_write, held until dmem_ack.
  - On ack with mem_read: go to WB.
  - On ack with mem_write: pc_we=1 and retire=1, then go to FETCH.
- WB (1 cycle): reg_we=1, pc_we=1, retire=1, then go to FETCH.
- HALT: all strobes 0; stays in HALT until rst. halted=1.
- Latency with single-cycle acks: ALU op 4 cycles, load 5, store 4, branch 3.
- Timeout:
  - Wait counter clears on entry to FETCH or MEM and increments each request cycle without an ack.
  - An ack is honoured while counter < MEM_TIMEOUT.
  - When counter == MEM_TIMEOUT with no ack: go to HALT and set timeout_err. A later ack is ignored.
  - MEM_TIMEOUT=0 means wait forever.
- An ack arriving when its request is not asserted is ignored and has no state effect.
- dec_* inputs are sampled only in DECODE, EXEC and MEM; they must be stable from ir_we until retire.
- retired_cnt increments on each retire and wraps modulo 2^CNT_WIDTH.
- Reset mid-operation (any state, including with a request pending): next cycle is state FETCH with no strobes; the pending access is abandoned and any late ack is ignored.

Test Plan:
- ALU op: rst 2 cycles, imem_ack on the first request cycle, reg_write=1 → states 0,1,2,4,0; ir_we at cycle 0, reg_we/pc_we/retire at cycle 3; retired_cnt=1.
- Load with 3-cycle dmem latency (ack on the 3rd MEM cycle): mem_read=1, reg_write=1 → dmem_req high 3 cycles with dmem_we=0, then WB; total 7 cycles; retire once.
- Store then branch back-to-back:
  - Store (mem_write=1, reg_write=0): dmem_we=1, no reg_we, retire after ack.
  - Branch (all dec=0): pc_we in EXEC, no dmem_req.
  - retired_cnt=2.
- MEM_TIMEOUT=4, imem_ack never arrives → HALT after 4 request cycles, timeout_err=1; imem_ack in cycle 6 has no effect; rst clears state to FETCH and timeout_err to 0.
- dec_illegal=1 in DECODE → HALT, illegal_err=1; no pc_we/retire; stuck for 20 cycles.
- CNT_WIDTH=4: 17 NOP retirements → retired_cnt=1 (wrap). Assert rst while dmem_req is high → next cycle FETCH, strobes 0, retired_cnt=0.

Source files
------------

// File: rtl/multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV64 core.
// Strobes are decoded from the registered state and the ack inputs; state, counters and errors are flops.
module multicycle_sequencer #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 imem_req,
    input  logic                 imem_ack,
    output logic                 dmem_req,
    output logic                 dmem_we,
    input  logic                 dmem_ack,
    input  logic                 dec_mem_read,
    input  logic                 dec_mem_write,
    input  logic                 dec_reg_write,
    input  logic                 dec_illegal,
    output logic                 ir_we,
    output logic                 pc_we,
    output logic                 reg_we,
    output logic                 retire,
    output logic [CNT_WIDTH-1:0] retired_cnt,
    output logic [2:0]           state,
    output logic                 halted,
    output logic                 illegal_err,
    output logic                 timeout_err
);
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 2);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic [WAIT_W-1:0]    wait_q, wait_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 illegal_q, illegal_d;
    logic                 timeout_q, timeout_d;
    logic                 expired;

    // The last unacked request cycle brings the count to MEM_TIMEOUT, so halt right there.
    assign expired = (MEM_TIMEOUT != 0) && (wait_q == WAIT_W'(MEM_TIMEOUT - 1));

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        cnt_d     = cnt_q;
        illegal_d = illegal_q;
        timeout_d = timeout_q;
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        reg_we    = 1'b0;
        retire    = 1'b0;
        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_we   = 1'b1;
                    state_d = S_DECODE;
                end else if (expired) begin
                    state_d   = S_HALT;
                    timeout_d = 1'b1;
                end else if (MEM_TIMEOUT != 0) begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_DECODE: begin
                if (dec_illegal || (dec_mem_read && dec_mem_write)) begin
                    state_d   = S_HALT;
                    illegal_d = 1'b1;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (dec_mem_read || dec_mem_write) begin
                    state_d = S_MEM;
                end else if (dec_reg_write) begin
                    state_d = S_WB;
                end else begin
                    pc_we   = 1'b1;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = dec_mem_write;
                if (dmem_ack) begin
                    if (dec_mem_read) begin
                        state_d = S_WB;
                    end else begin
                        pc_we   = 1'b1;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                end else if (expired) begin
                    state_d   = S_HALT;
                    timeout_d = 1'b1;
                end else if (MEM_TIMEOUT != 0) begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_WB: begin
                reg_we  = 1'b1;
                pc_we   = 1'b1;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_HALT: ;
            default: state_d = S_HALT;
        endcase
        // Any state change lands in a fresh wait window (covers entry to FETCH and MEM).
        if (state_d != state_q) wait_d = '0;
        if (retire) cnt_d = cnt_q + CNT_WIDTH'(1);
        if (rst) begin
            imem_req = 1'b0;
            dmem_req = 1'b0;
            dmem_we  = 1'b0;
            ir_we    = 1'b0;
            pc_we    = 1'b0;
            reg_we   = 1'b0;
            retire   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            wait_q    <= '0;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    assign state       = state_q;
    assign halted      = (state_q == S_HALT);
    assign retired_cnt = cnt_q;
    assign illegal_err = illegal_q;
    assign timeout_err = timeout_q;
endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: per-scenario tasks plus a retire scoreboard.
module tb_multicycle_sequencer;
    logic       clk = 1'b0;
    logic       rst, imem_ack, dmem_ack;
    logic       dec_mem_read, dec_mem_write, dec_reg_write, dec_illegal;
    logic       imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_we, retire;
    logic [3:0] retired_cnt;
    logic [2:0] state;
    logic       halted, illegal_err, timeout_err;

    int         errors = 0;
    int         checks = 0;
    logic [3:0] exp_cnt = 4'd0;

    typedef struct packed {
        logic       rw;
        logic [3:0] cnt;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    multicycle_sequencer #(.MEM_TIMEOUT(4), .CNT_WIDTH(4)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_ack(imem_ack),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .dec_mem_read(dec_mem_read), .dec_mem_write(dec_mem_write),
        .dec_reg_write(dec_reg_write), .dec_illegal(dec_illegal),
        .ir_we(ir_we), .pc_we(pc_we), .reg_we(reg_we), .retire(retire),
        .retired_cnt(retired_cnt), .state(state), .halted(halted),
        .illegal_err(illegal_err), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Every retire pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (retire) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_retire state=%0d cnt=%0d", state, retired_cnt);
            end else begin
                mon_e = exp_q.pop_front();
                if (reg_we !== mon_e.rw || retired_cnt !== mon_e.cnt) begin
                    errors++;
                    $display("FAIL retire_sb got reg_we=%b cnt=%0d exp reg_we=%b cnt=%0d",
                             reg_we, retired_cnt, mon_e.rw, mon_e.cnt);
                end
            end
        end
    end

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; imem_ack = 1'b1; dmem_ack = 1'b1;
        dec_mem_read = 0; dec_mem_write = 0; dec_reg_write = 0; dec_illegal = 0;
        for (int i = 0; i < 2; i++) begin
            nxt; #3;
            checks++;
            if (state !== 3'd0 || retired_cnt !== 4'd0 || illegal_err !== 1'b0 ||
                timeout_err !== 1'b0 || halted !== 1'b0) begin
                errors++;
                $display("FAIL reset_state got st=%0d cnt=%0d ie=%b te=%b h=%b exp 0", state,
                         retired_cnt, illegal_err, timeout_err, halted);
            end
            checks++;
            if ({imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_we, retire} !== 7'b0) begin
                errors++;
                $display("FAIL reset_strobes got %b exp 0",
                         {imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_we, retire});
            end
        end
        imem_ack = 1'b0; dmem_ack = 1'b0; exp_cnt = 4'd0;
        nxt;
    endtask

    task automatic test_alu;
        rst = 1'b0; imem_ack = 1'b1; dec_reg_write = 1'b1;
        #3; checks++;
        if (state !== 3'd0 || imem_req !== 1'b1 || ir_we !== 1'b1) begin
            errors++;
            $display("FAIL alu_fetch got st=%0d req=%b ir_we=%b exp 0,1,1", state, imem_req, ir_we);
        end
        exp_q.push_back('{rw: 1'b1, cnt: exp_cnt}); exp_cnt++;
        nxt; imem_ack = 1'b0; #3; checks++;
        if (state !== 3'd1 || ir_we !== 1'b0) begin
            errors++; $display("FAIL alu_decode got st=%0d ir_we=%b exp 1,0", state, ir_we);
        end
        nxt; #3; checks++;
        if (state !== 3'd2 || pc_we !== 1'b0) begin
            errors++; $display("FAIL alu_exec got st=%0d pc_we=%b exp 2,0", state, pc_we);
        end
        nxt; #3; checks++;
        if (state !== 3'd4 || reg_we !== 1'b1 || pc_we !== 1'b1) begin
            errors++;
            $display("FAIL alu_wb got st=%0d reg_we=%b pc_we=%b exp 4,1,1", state, reg_we, pc_we);
        end
        nxt;
    endtask

    task automatic test_load;
        imem_ack = 1'b1; dec_mem_read = 1'b1; dec_reg_write = 1'b1; dec_mem_write = 1'b0;
        #3; checks++;
        if (state !== 3'd0 || ir_we !== 1'b1 || retired_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL load_fetch got st=%0d ir_we=%b cnt=%0d exp 0,1,%0d", state, ir_we,
                     retired_cnt, exp_cnt);
        end
        exp_q.push_back('{rw: 1'b1, cnt: exp_cnt}); exp_cnt++;
        nxt; imem_ack = 1'b0; nxt; #3; checks++;
        if (state !== 3'd2) begin
            errors++; $display("FAIL load_exec got st=%0d exp 2", state);
        end
        nxt;
        for (int i = 0; i < 3; i++) begin
            dmem_ack = (i == 2);
            #3; checks++;
            if (state !== 3'd3 || dmem_req !== 1'b1 || dmem_we !== 1'b0 || reg_we !== 1'b0) begin
                errors++;
                $display("FAIL load_mem%0d got st=%0d req=%b we=%b rwe=%b exp 3,1,0,0", i, state,
                         dmem_req, dmem_we, reg_we);
            end
            nxt;
        end
        dmem_ack = 1'b0; #3; checks++;
        if (state !== 3'd4 || reg_we !== 1'b1 || dmem_req !== 1'b0) begin
            errors++;
            $display("FAIL load_wb got st=%0d reg_we=%b req=%b exp 4,1,0", state, reg_we, dmem_req);
        end
        nxt;
        dec_mem_read = 1'b0; dec_reg_write = 1'b0;
    endtask

    task automatic test_store_branch;
        imem_ack = 1'b1; dec_mem_write = 1'b1;
        #3; checks++;
        if (state !== 3'd0 || retired_cnt !== exp_cnt) begin
            errors++; $display("FAIL store_fetch got st=%0d cnt=%0d exp 0,%0d", state, retired_cnt, exp_cnt);
        end
        exp_q.push_back('{rw: 1'b0, cnt: exp_cnt}); exp_cnt++;
        nxt; imem_ack = 1'b0; nxt; #3; checks++;
        if (state !== 3'd2 || pc_we !== 1'b0) begin
            errors++; $display("FAIL store_exec got st=%0d pc_we=%b exp 2,0", state, pc_we);
        end
        nxt; dmem_ack = 1'b1; #3; checks++;
        if (state !== 3'd3 || dmem_req !== 1'b1 || dmem_we !== 1'b1 || pc_we !== 1'b1 || reg_we !== 1'b0) begin
            errors++;
            $display("FAIL store_mem got st=%0d req=%b we=%b pc=%b rwe=%b exp 3,1,1,1,0", state,
                     dmem_req, dmem_we, pc_we, reg_we);
        end
        nxt; dmem_ack = 1'b0; dec_mem_write = 1'b0; imem_ack = 1'b1;
        #3; checks++;
        if (state !== 3'd0 || ir_we !== 1'b1 || retired_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL branch_fetch got st=%0d ir_we=%b cnt=%0d exp 0,1,%0d", state, ir_we,
                     retired_cnt, exp_cnt);
        end
        exp_q.push_back('{rw: 1'b0, cnt: exp_cnt}); exp_cnt++;
        nxt; imem_ack = 1'b0; nxt; #3; checks++;
        if (state !== 3'd2 || pc_we !== 1'b1 || dmem_req !== 1'b0 || reg_we !== 1'b0) begin
            errors++;
            $display("FAIL branch_exec got st=%0d pc=%b req=%b rwe=%b exp 2,1,0,0", state, pc_we,
                     dmem_req, reg_we);
        end
        nxt;
    endtask

    task automatic test_ack_at_limit;
        for (int i = 0; i < 4; i++) begin
            imem_ack = (i == 3);
            #3; checks++;
            if (state !== 3'd0 || imem_req !== 1'b1 || ir_we !== imem_ack) begin
                errors++;
                $display("FAIL limit_fetch%0d got st=%0d req=%b ir_we=%b exp 0,1,%b", i, state,
                         imem_req, ir_we, imem_ack);
            end
            nxt;
        end
        exp_q.push_back('{rw: 1'b0, cnt: exp_cnt}); exp_cnt++;
        imem_ack = 1'b0; #3; checks++;
        if (state !== 3'd1 || timeout_err !== 1'b0) begin
            errors++; $display("FAIL limit_decode got st=%0d te=%b exp 1,0", state, timeout_err);
        end
        nxt; nxt;
    endtask

    task automatic test_timeout;
        for (int i = 0; i < 4; i++) begin
            #3; checks++;
            if (state !== 3'd0 || imem_req !== 1'b1) begin
                errors++; $display("FAIL to_req%0d got st=%0d req=%b exp 0,1", i, state, imem_req);
            end
            nxt;
        end
        #3; checks++;
        if (state !== 3'd5 || halted !== 1'b1 || timeout_err !== 1'b1 || illegal_err !== 1'b0 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL to_halt got st=%0d h=%b te=%b ie=%b req=%b exp 5,1,1,0,0", state, halted,
                     timeout_err, illegal_err, imem_req);
        end
        nxt; nxt; imem_ack = 1'b1; #3; checks++;
        if (state !== 3'd5 || ir_we !== 1'b0) begin
            errors++; $display("FAIL to_late_ack got st=%0d ir_we=%b exp 5,0", state, ir_we);
        end
        nxt; imem_ack = 1'b0; #3; checks++;
        if (state !== 3'd5 || timeout_err !== 1'b1) begin
            errors++; $display("FAIL to_stuck got st=%0d te=%b exp 5,1", state, timeout_err);
        end
        rst = 1'b1; nxt; #3; checks++;
        if (state !== 3'd0 || timeout_err !== 1'b0 || retired_cnt !== 4'd0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL to_reset got st=%0d te=%b cnt=%0d h=%b exp 0,0,0,0", state, timeout_err,
                     retired_cnt, halted);
        end
        exp_cnt = 4'd0;
        nxt;
    endtask

    task automatic test_illegal;
        rst = 1'b0; imem_ack = 1'b1; dec_illegal = 1'b1;
        #3; nxt; imem_ack = 1'b0; #3; checks++;
        if (state !== 3'd1) begin
            errors++; $display("FAIL ill_decode got st=%0d exp 1", state);
        end
        nxt;
        for (int i = 0; i < 20; i++) begin
            imem_ack = i[0]; dmem_ack = i[1];
            #3; checks++;
            if (state !== 3'd5 || halted !== 1'b1 || illegal_err !== 1'b1 ||
                {imem_req, dmem_req, ir_we, pc_we, reg_we, retire} !== 6'b0) begin
                errors++;
                $display("FAIL ill_halt%0d got st=%0d h=%b ie=%b strobes=%b exp 5,1,1,0", i, state,
                         halted, illegal_err, {imem_req, dmem_req, ir_we, pc_we, reg_we, retire});
            end
            nxt;
        end
        imem_ack = 1'b0; dmem_ack = 1'b0; dec_illegal = 1'b0;
        rst = 1'b1; nxt; #3; checks++;
        if (state !== 3'd0 || illegal_err !== 1'b0) begin
            errors++; $display("FAIL ill_reset got st=%0d ie=%b exp 0,0", state, illegal_err);
        end
        exp_cnt = 4'd0;
        nxt;
    endtask

    task automatic test_wrap_midreset;
        rst = 1'b0;
        for (int n = 0; n < 17; n++) begin
            imem_ack = 1'b1; #3; checks++;
            if (state !== 3'd0 || retired_cnt !== exp_cnt) begin
                errors++;
                $display("FAIL nop%0d_fetch got st=%0d cnt=%0d exp 0,%0d", n, state, retired_cnt, exp_cnt);
            end
            exp_q.push_back('{rw: 1'b0, cnt: exp_cnt}); exp_cnt++;
            nxt; imem_ack = 1'b0; nxt; nxt;
        end
        #3; checks++;
        if (retired_cnt !== 4'd1) begin
            errors++; $display("FAIL cnt_wrap got %0d exp 1", retired_cnt);
        end
        imem_ack = 1'b1; dec_mem_read = 1'b1; dec_reg_write = 1'b1;
        nxt; imem_ack = 1'b0; nxt; nxt; #3; checks++;
        if (state !== 3'd3 || dmem_req !== 1'b1) begin
            errors++; $display("FAIL mr_mem got st=%0d req=%b exp 3,1", state, dmem_req);
        end
        nxt; rst = 1'b1; #3; checks++;
        if ({imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_we, retire} !== 7'b0) begin
            errors++;
            $display("FAIL mr_forced got %b exp 0", {imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_we, retire});
        end
        nxt; rst = 1'b0; dmem_ack = 1'b1; dec_mem_read = 1'b0; dec_reg_write = 1'b0;
        #3; checks++;
        if (state !== 3'd0 || dmem_req !== 1'b0 || reg_we !== 1'b0 || imem_req !== 1'b1 || retired_cnt !== 4'd0) begin
            errors++;
            $display("FAIL mr_after got st=%0d dreq=%b rwe=%b ireq=%b cnt=%0d exp 0,0,0,1,0", state,
                     dmem_req, reg_we, imem_req, retired_cnt);
        end
        nxt; dmem_ack = 1'b0; #3; checks++;
        if (state !== 3'd0 || retired_cnt !== 4'd0) begin
            errors++; $display("FAIL mr_late_ack got st=%0d cnt=%0d exp 0,0", state, retired_cnt);
        end
        nxt;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_store_branch();
        test_ack_at_limit();
        test_timeout();
        test_illegal();
        test_wrap_midreset();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL sb_drain got %0d pending exp 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
